// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle between the ID/EX stage logic and the hazard controller.
// HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_controller_if;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        idUseRs;
  logic        idUseRt;
  logic        idIsMulDiv;
  logic        idIsDiv;
  logic        idUsesHiLo;
  logic        exMemRead;
  logic [4:0]  exWriteReg;
  logic        exTakeBranch;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        ifIdFlush;
  logic        idExFlush;
  logic        mdStart;
  logic        mdBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCount;
`endif

  // Pipeline side: presents ID/EX decode fields, consumes stage controls.
  modport master (
    output idRs, idRt, idUseRs, idUseRt, idIsMulDiv, idIsDiv, idUsesHiLo,
    output exMemRead, exWriteReg, exTakeBranch,
`ifdef HAZARD_PERF_EN
    input  stallCycles, flushCount,
`endif
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdStart, mdBusy
  );

  // Controller side.
  modport slave (
    input  idRs, idRt, idUseRs, idUseRt, idIsMulDiv, idIsDiv, idUsesHiLo,
    input  exMemRead, exWriteReg, exTakeBranch,
`ifdef HAZARD_PERF_EN
    output stallCycles, flushCount,
`endif
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdStart, mdBusy
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / branch / mult-div hazard sequencer for the 5-stage core; owns the mult/div busy counter.
// Optional HAZARD_PERF_EN adds stallCycles and flushCount performance counters.
module hazard_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input logic                clk,
  input logic                resetn,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_HOLD = 2'd1,
    MD_WAIT   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic             md_busy;
  logic             lu_haz;
  logic             md_haz;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_start;

  assign md_busy = (md_cnt != '0);
  assign lu_haz  = hz.exMemRead && (hz.exWriteReg != 5'd0) &&
                   (((hz.exWriteReg == hz.idRs) && hz.idUseRs) ||
                    ((hz.exWriteReg == hz.idRt) && hz.idUseRt));
  // A count of 1 means the result lands on the next edge, so HI/LO readers may go.
  assign md_haz  = hz.idUsesHiLo && md_busy && (md_cnt != CNT_W'(1));

  // Stage controls and next state, priority branch > load-use > mult/div > normal.
  always_comb begin
    state_nxt   = RUN;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_start    = 1'b0;
    if (!resetn) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hz.exTakeBranch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        LOAD_HOLD: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_nxt   = md_haz ? MD_WAIT : RUN;
        end
        default: begin
          if (lu_haz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = LOAD_HOLD;
          end else if (md_haz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = MD_WAIT;
          end else begin
            md_start    = hz.idIsMulDiv;
          end
        end
      endcase
    end
  end

  // State and mult/div latency counter; the counter keeps running across branches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (md_start) begin
        md_cnt <= hz.idIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (md_busy) begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

  assign hz.pcWrite   = pc_write;
  assign hz.ifIdWrite = if_id_write;
  assign hz.ifIdFlush = if_id_flush;
  assign hz.idExFlush = id_ex_flush;
  assign hz.mdStart   = md_start;
  assign hz.mdBusy    = resetn && md_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write)        stall_cycles <= stall_cycles + 32'd1;
      if (hz.exTakeBranch)  flush_count  <= flush_count + 32'd1;
    end
  end

  assign hz.stallCycles = stall_cycles;
  assign hz.flushCount  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the driver queues per-cycle expected controls,
// a negedge monitor pops and compares them.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic resetn;

  hazard_controller_if hz_if ();

  hazard_controller #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz_if)
  );

  always #5 clk = ~clk;

  // Expected vector order: {pcWrite, ifIdWrite, ifIdFlush, idExFlush, mdStart, mdBusy}
  localparam logic [5:0] RST   = 6'b001100;
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] BR    = 6'b111100;
  localparam logic [5:0] START = 6'b000010;
  localparam logic [5:0] BUSY  = 6'b000001;

  typedef struct {
    string      nm;
    logic [5:0] exp;
    logic       rst_n;
    logic       br;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic cyc(input string nm, input logic [5:0] ex);
    exp_t e;
    e.nm    = nm;
    e.exp   = ex;
    e.rst_n = resetn;
    e.br    = hz_if.exTakeBranch;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz_if.idRs         = 5'd0;
    hz_if.idRt         = 5'd0;
    hz_if.idUseRs      = 1'b0;
    hz_if.idUseRt      = 1'b0;
    hz_if.idIsMulDiv   = 1'b0;
    hz_if.idIsDiv      = 1'b0;
    hz_if.idUsesHiLo   = 1'b0;
    hz_if.exMemRead    = 1'b0;
    hz_if.exWriteReg   = 5'd0;
    hz_if.exTakeBranch = 1'b0;
  endtask

  // Monitor: one control vector per cycle, compared away from the active edge.
  initial begin
    logic [5:0] got;
    exp_t       e;
`ifdef HAZARD_PERF_EN
    int m_stall = 0;
    int m_flush = 0;
`endif
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = {hz_if.pcWrite, hz_if.ifIdWrite, hz_if.ifIdFlush,
               hz_if.idExFlush, hz_if.mdStart, hz_if.mdBusy};
        total++;
        if (got === e.exp) passed++;
        else $display("FAIL %s: got %b want %b", e.nm, got, e.exp);
`ifdef HAZARD_PERF_EN
        if (e.rst_n) begin
          total++;
          if (hz_if.stallCycles === 32'(m_stall) && hz_if.flushCount === 32'(m_flush)) passed++;
          else $display("FAIL %s_perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        e.nm, hz_if.stallCycles, hz_if.flushCount, m_stall, m_flush);
        end
        if (!e.rst_n) begin
          m_stall = 0;
          m_flush = 0;
        end else begin
          if (!e.exp[5]) m_stall++;
          if (e.br)      m_flush++;
        end
`endif
      end
    end
  end

  initial begin
    resetn = 1'b0;
    clr();
    @(posedge clk);
    #1;
    cyc("rst0", RST);
    cyc("rst1", RST);
    resetn = 1'b1;
    cyc("idle", NORM);

    // Load-use on rs: exactly two bubbles.
    hz_if.exMemRead = 1'b1; hz_if.exWriteReg = 5'd8; hz_if.idRs = 5'd8; hz_if.idUseRs = 1'b1;
    cyc("lu_rs0", STALL);
    hz_if.exMemRead = 1'b0; hz_if.exWriteReg = 5'd0;
    cyc("lu_rs1", STALL);
    cyc("lu_rs2", NORM);
    clr();

    // Destination $zero never hazards.
    hz_if.exMemRead = 1'b1; hz_if.exWriteReg = 5'd0; hz_if.idRs = 5'd0; hz_if.idUseRs = 1'b1;
    cyc("lu_r0", NORM);
    // Match on rt only counts when rt is read.
    hz_if.exWriteReg = 5'd9; hz_if.idRs = 5'd3; hz_if.idRt = 5'd9; hz_if.idUseRt = 1'b0;
    cyc("lu_rt_unused", NORM);
    hz_if.idUseRt = 1'b1;
    cyc("lu_rt0", STALL);
    clr();
    cyc("lu_rt1", STALL);
    cyc("lu_rt2", NORM);

    // Branch beats a simultaneous load-use; no stall follows.
    hz_if.exMemRead = 1'b1; hz_if.exWriteReg = 5'd8; hz_if.idRs = 5'd8; hz_if.idUseRs = 1'b1;
    hz_if.exTakeBranch = 1'b1;
    cyc("br_lu", BR);
    clr();
    cyc("br_after", NORM);

    // div then mflo: 31 stalls, advance when the count reaches 1.
    hz_if.idIsMulDiv = 1'b1; hz_if.idIsDiv = 1'b1; hz_if.idUsesHiLo = 1'b1;
    cyc("div_start", NORM | START);
    hz_if.idIsMulDiv = 1'b0; hz_if.idIsDiv = 1'b0;
    for (int i = 0; i < 31; i++) cyc($sformatf("mflo_stall%0d", i), STALL | BUSY);
    cyc("mflo_go", NORM | BUSY);
    clr();
    cyc("div_done", NORM);

    // Back-to-back mult: second stalls 3 cycles, then restarts the counter.
    hz_if.idIsMulDiv = 1'b1; hz_if.idUsesHiLo = 1'b1;
    cyc("mul1_start", NORM | START);
    for (int i = 0; i < 3; i++) cyc($sformatf("mul2_stall%0d", i), STALL | BUSY);
    cyc("mul2_start", NORM | START | BUSY);
    clr();
    for (int i = 0; i < 4; i++) cyc($sformatf("mul2_busy%0d", i), NORM | BUSY);
    cyc("mul2_done", NORM);

    // Reset at count 10 during a divide stall abandons the divide.
    hz_if.idIsMulDiv = 1'b1; hz_if.idIsDiv = 1'b1; hz_if.idUsesHiLo = 1'b1;
    cyc("div2_start", NORM | START);
    hz_if.idIsMulDiv = 1'b0; hz_if.idIsDiv = 1'b0;
    for (int i = 0; i < 22; i++) cyc($sformatf("div2_stall%0d", i), STALL | BUSY);
    resetn = 1'b0;
    cyc("div2_rst", RST);
    resetn = 1'b1;
    cyc("div2_post", NORM);
    clr();

    // Load-use after reset, for the performance counters as well.
    hz_if.exMemRead = 1'b1; hz_if.exWriteReg = 5'd4; hz_if.idRt = 5'd4; hz_if.idUseRt = 1'b1;
    cyc("lu_post0", STALL);
    clr();
    cyc("lu_post1", STALL);
    cyc("lu_post2", NORM);
    cyc("tail", NORM);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
